// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types and helpers for the debug-module bus arbiter.
// Imported by dm_bus_arbiter and dm_bus_arb_fifo.
package dm_bus_arbiter_pkg;

  // Bus request payload, sized for the widest bus and truncated at use
  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } bus_req_t;

  // Port-index width, never narrower than one bit
  function automatic int unsigned dm_bus_arb_idx_w(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DmBusArbIdxW = dm_bus_arb_idx_w(2);

endpackage

// File: rtl/dm_bus_arb_fifo.sv
// Outstanding-transaction FIFO holding the issuing port index.
// Synchronous active-high reset; push is dropped when full.
module dm_bus_arb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, wrapping pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
    end
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // State registers, flushed on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the debug-module system-bus master port.
// Optional response watchdog enabled by DM_BUS_ARB_TIMEOUT_EN.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NrPorts-1:0]          req_i,
  input  logic [NrPorts-1:0]          we_i,
  input  logic [NrPorts*BusWidth-1:0] addr_i,
  input  logic [NrPorts*BusWidth-1:0] wdata_i,
  input  logic [NrPorts*BusWidth/8-1:0] be_i,
  output logic [NrPorts-1:0]          gnt_o,
  output logic [NrPorts-1:0]          rvalid_o,
  output logic [BusWidth-1:0]         rdata_o,
  output logic [NrPorts-1:0]          err_o,
  output logic                        master_req_o,
  output logic [BusWidth-1:0]         master_add_o,
  output logic                        master_we_o,
  output logic [BusWidth-1:0]         master_wdata_o,
  output logic [BusWidth/8-1:0]       master_be_o,
  input  logic                        master_gnt_i,
  input  logic                        master_r_valid_i,
  input  logic [BusWidth-1:0]         master_r_rdata_i
);

  localparam int unsigned IdxW = dm_bus_arb_idx_w(NrPorts);
  localparam int unsigned BeW  = BusWidth / 8;

  logic [IdxW-1:0] rr_q, rr_d, win, head;
  logic            found, full, empty, hs, pop, resp_ok, timeout;
  bus_req_t        win_req;

  // First requesting port at or after the round-robin pointer
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    for (int k = 0; k < int'(NrPorts); k++) begin
      if (!found && req_i[(int'(rr_q) + k) % int'(NrPorts)]) begin
        win   = IdxW'((int'(rr_q) + k) % int'(NrPorts));
        found = 1'b1;
      end
    end
  end

  assign master_req_o = (|req_i) & ~full & ~rst_i;
  assign hs           = master_req_o & master_gnt_i;

  // Winner payload onto the bus, zero while idle
  always_comb begin
    win_req = '0;
    if (master_req_o) begin
      win_req.we    = we_i[win];
      win_req.addr  = 64'(addr_i[int'(win)*BusWidth +: BusWidth]);
      win_req.wdata = 64'(wdata_i[int'(win)*BusWidth +: BusWidth]);
      win_req.be    = 8'(be_i[int'(win)*BeW +: BeW]);
    end
  end

  assign master_we_o    = win_req.we;
  assign master_add_o   = win_req.addr[BusWidth-1:0];
  assign master_wdata_o = win_req.wdata[BusWidth-1:0];
  assign master_be_o    = win_req.be[BeW-1:0];

  // Grant decode and pointer advance past the granted port
  always_comb begin
    gnt_o = '0;
    rr_d  = rr_q;
    if (hs) begin
      gnt_o[win] = 1'b1;
      rr_d = (win == IdxW'(NrPorts - 1)) ? '0 : win + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  dm_bus_arb_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (win),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

`ifdef DM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned WdW   = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned DropW = $clog2(MaxOutstanding + 1);

  logic [WdW-1:0]   wd_q, wd_d;
  logic [DropW-1:0] drop_q, drop_d;
  logic             swallow;

  assign timeout = ~rst_i & ~empty & ~master_r_valid_i &
                   (wd_q == WdW'(TimeoutCycles - 1));
  assign swallow = master_r_valid_i & (drop_q != '0);
  assign resp_ok = ~rst_i & master_r_valid_i & ~empty & (drop_q == '0);
  assign pop     = resp_ok | timeout;
  assign rdata_o = timeout ? '0 : master_r_rdata_i;

  // Watchdog count and count of late responses still to swallow
  always_comb begin
    wd_d   = wd_q;
    drop_d = drop_q;
    if (empty || master_r_valid_i || pop) wd_d = '0;
    else                                  wd_d = wd_q + 1'b1;
    if (swallow) drop_d = drop_q - 1'b1;
    else if (timeout && drop_q < DropW'(MaxOutstanding))
      drop_d = drop_q + 1'b1;
  end

  // Watchdog and drop registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q   <= '0;
      drop_q <= '0;
    end else begin
      wd_q   <= wd_d;
      drop_q <= drop_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign resp_ok = ~rst_i & master_r_valid_i & ~empty;
  assign pop     = resp_ok;
  assign rdata_o = master_r_rdata_i;
`endif

  // Route the response (or timeout error) to the oldest issuer
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    if (pop)     rvalid_o[head] = 1'b1;
    if (timeout) err_o[head]    = 1'b1;
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Randomized and directed bench for dm_bus_arbiter.
// Queue-based reference model; watchdog checks under DM_BUS_ARB_TIMEOUT_EN.
module tb_dm_bus_arbiter;

  localparam int N  = 2;
  localparam int BW = 32;
  localparam int MO = 2;
`ifdef DM_BUS_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0, we = '0;
  logic [N*BW-1:0] addr = '0, wdata = '0;
  logic [N*BW/8-1:0] be = '0;
  logic [N-1:0]    gnt, rvalid, err;
  logic [BW-1:0]   rdata, m_add, m_wdata;
  logic [BW-1:0]   m_rdata = '0;
  logic [BW/8-1:0] m_be;
  logic            m_req, m_we;
  logic            m_gnt = 1'b0, m_rv = 1'b0;

  dm_bus_arbiter #(
    .NrPorts        (N),
    .BusWidth       (BW),
    .MaxOutstanding (MO),
    .TimeoutCycles  (TO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .we_i             (we),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .be_i             (be),
    .gnt_o            (gnt),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .err_o            (err),
    .master_req_o     (m_req),
    .master_add_o     (m_add),
    .master_we_o      (m_we),
    .master_wdata_o   (m_wdata),
    .master_be_o      (m_be),
    .master_gnt_i     (m_gnt),
    .master_r_valid_i (m_rv),
    .master_r_rdata_i (m_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: issuer queue, next-priority port, watchdog, drops
  int rr_m = 0;
  int q[$];
  int wd_m = 0;
  int drop_m = 0;

  logic [N-1:0]  o_gnt, o_rv, o_err;
  logic          o_mreq;
  logic [BW-1:0] o_add, o_rdata;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model
  task automatic step();
    int win;
    bit mreq, hs, to, okr, was_empty;
    logic [N-1:0] e_gnt, e_rv, e_err;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (rr_m + k) % N;
      if (req[p]) begin
        win = p;
        break;
      end
    end
    mreq = !rst && (win >= 0) && (q.size() < MO);
    hs   = mreq && m_gnt;
    to   = 1'b0;
`ifdef DM_BUS_ARB_TIMEOUT_EN
    to = !rst && q.size() > 0 && !m_rv && wd_m == TO - 1;
`endif
    okr = !rst && m_rv && q.size() > 0 && drop_m == 0;
    e_gnt = '0;
    e_rv  = '0;
    e_err = '0;
    if (hs) e_gnt[win] = 1'b1;
    if (okr || to) e_rv[q[0]] = 1'b1;
    if (to) e_err[q[0]] = 1'b1;
    chk("master_req", 64'(m_req), 64'(mreq));
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("rvalid", 64'(rvalid), 64'(e_rv));
    chk("err", 64'(err), 64'(e_err));
    chk("rdata", 64'(rdata), to ? 64'd0 : 64'(m_rdata));
    if (mreq) begin
      chk("addr", 64'(m_add), 64'(addr[win*BW +: BW]));
      chk("we", 64'(m_we), 64'(we[win]));
      chk("wdata", 64'(m_wdata), 64'(wdata[win*BW +: BW]));
      chk("be", 64'(m_be), 64'(be[win*BW/8 +: BW/8]));
    end
    o_gnt = gnt; o_rv = rvalid; o_err = err;
    o_mreq = m_req; o_add = m_add; o_rdata = rdata;
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr_m = 0; wd_m = 0; drop_m = 0;
    end else begin
      was_empty = (q.size() == 0);
      if (okr || to) void'(q.pop_front());
      if (hs) begin
        q.push_back(win);
        rr_m = (win + 1) % N;
      end
      if (was_empty || m_rv || okr || to) wd_m = 0;
      else wd_m++;
      if (m_rv && drop_m > 0) drop_m--;
      else if (to && drop_m < MO) drop_m++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; m_gnt = 1'b0; m_rv = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    int n;

    do_reset();
    chk("reset_mreq", 64'(o_mreq), 64'd0);
    chk("reset_rvalid", 64'(o_rv), 64'd0);

    // Both ports held: grants alternate, addresses follow
    addr[0 +: BW] = 32'hA0; addr[BW +: BW] = 32'hB1;
    req = 2'b11; m_gnt = 1'b1; m_rv = 1'b1;
    exp_g = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_gnt", 64'(o_gnt), 64'(exp_g));
      chk("t1_addr", 64'(o_add), (exp_g == 2'b01) ? 64'hA0 : 64'hB1);
      exp_g = ~exp_g;
    end

    // Single read from port 1 answered 3 cycles later
    do_reset();
    req = 2'b10; we = '0; addr[BW +: BW] = 32'h1000; m_gnt = 1'b1;
    step();
    chk("t2_gnt", 64'(o_gnt), 64'h2);
    req = '0;
    repeat (3) step();
    m_rv = 1'b1; m_rdata = 32'hDEADBEEF;
    step();
    chk("t2_rvalid", 64'(o_rv), 64'h2);
    chk("t2_rdata", 64'(o_rdata), 64'hDEADBEEF);
    m_rv = 1'b0;

    // Queue fills at two outstanding; resume after a response
    do_reset();
    req = 2'b01; m_gnt = 1'b1; addr[0 +: BW] = 32'h10;
    step();
    addr[0 +: BW] = 32'h14;
    step();
    addr[0 +: BW] = 32'h18;
    step();
    chk("t3_full_req", 64'(o_mreq), 64'd0);
    m_rv = 1'b1;
    step();
    chk("t3_full_pop_req", 64'(o_mreq), 64'd0);
    chk("t3_pop_rvalid", 64'(o_rv), 64'h1);
    m_rv = 1'b0;
    step();
    chk("t3_resume", 64'(o_mreq), 64'd1);
    m_rv = 1'b1;
    req = '0;
    repeat (2) step();
    m_rv = 1'b0;

    // Push and pop together with one outstanding
    do_reset();
    req = 2'b01; m_gnt = 1'b1;
    step();
    req = 2'b10; m_rv = 1'b1;
    step();
    chk("t4_gnt", 64'(o_gnt), 64'h2);
    chk("t4_old_rvalid", 64'(o_rv), 64'h1);
    req = '0;
    step();
    chk("t4_next_rvalid", 64'(o_rv), 64'h2);
    step();
    chk("t4_empty", 64'(o_rv), 64'd0);
    m_rv = 1'b0;

    // Reset with two outstanding, stray response afterwards
    do_reset();
    req = 2'b11; m_gnt = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("t5_rst_req", 64'(o_mreq), 64'd0);
    chk("t5_rst_gnt", 64'(o_gnt), 64'd0);
    rst = 1'b0; req = '0; m_rv = 1'b1;
    step();
    chk("t5_stray", 64'(o_rv), 64'd0);
    m_rv = 1'b0;

`ifdef DM_BUS_ARB_TIMEOUT_EN
    // Unanswered read times out, late response swallowed
    do_reset();
    req = 2'b01; m_gnt = 1'b1;
    step();
    req = '0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (o_err != '0) begin
        n = i;
        break;
      end
    end
    chk("t6_timeout_cycle", 64'(n), 64'd8);
    chk("t6_err_rvalid", 64'(o_rv), 64'h1);
    m_rv = 1'b1;
    step();
    chk("t6_swallow", 64'(o_rv), 64'd0);
    m_rv = 1'b0; req = 2'b01;
    step();
    req = '0; m_rv = 1'b1; m_rdata = 32'h55AA;
    step();
    chk("t6_next_rvalid", 64'(o_rv), 64'h1);
    chk("t6_next_err", 64'(o_err), 64'd0);
    m_rv = 1'b0;
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p] = 1'b1;
          we[p] = 1'($urandom);
          addr[p*BW +: BW] = $urandom;
          wdata[p*BW +: BW] = $urandom;
          be[p*BW/8 +: BW/8] = 4'($urandom);
        end
      end
      m_gnt = ($urandom_range(0, 3) != 0);
      if ((c / 500) % 2 == 0) m_rv = ($urandom_range(0, 2) == 0);
      else                    m_rv = ($urandom_range(0, 19) == 0);
      m_rdata = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step();
      req = req & ~o_gnt;
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
